// File: rtl/cache_refill_engine.sv
// cache_refill_engine: AXI4 INCR read-burst master that fetches one full cache
// line on behalf of the data cache FSM. It issues one line-aligned AR, collects
// BLOCK_WORDS beats into a line buffer and then raises a one-cycle completion
// pulse, with a sticky error flag that is valid alongside that pulse.
module cache_refill_engine #(
  parameter int ADDR_W      = 64,
  parameter int DATA_W      = 32,
  parameter int BLOCK_WORDS = 16
) (
  input  logic                          clk,
  input  logic                          arst,
  input  logic                          i_start_read,
  input  logic [ADDR_W-1:0]             i_addr,
  output logic [BLOCK_WORDS*DATA_W-1:0] o_rd_block,
  output logic                          o_r_last,
  output logic                          o_err,
  output logic [ADDR_W-1:0]             o_araddr,
  output logic [7:0]                    o_arlen,
  output logic                          o_arvalid,
  input  logic                          i_arready,
  input  logic [DATA_W-1:0]             i_rdata,
  input  logic [1:0]                    i_rresp,
  input  logic                          i_rlast,
  input  logic                          i_rvalid,
  output logic                          o_rready
);

  // Beat counter width and the number of byte-offset bits inside one line.
  localparam int CNT_W = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
  localparam int OFF_W = $clog2(BLOCK_WORDS * DATA_W / 8);
  localparam int LINE_W = BLOCK_WORDS * DATA_W;

  localparam logic [CNT_W-1:0]  LAST_IDX  = CNT_W'(BLOCK_WORDS - 1);
  localparam logic [ADDR_W-1:0] LINE_MASK = ~((ADDR_W'(1) << OFF_W) - ADDR_W'(1));

  // Controller states.
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ADDR = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_RESP = 3'd3;
  localparam logic [2:0] S_HOLD = 3'd4;

  logic [2:0]        state_q,   state_d;
  logic [ADDR_W-1:0] araddr_q,  araddr_d;
  logic              arvalid_q, arvalid_d;
  logic              rready_q,  rready_d;
  logic              r_last_q,  r_last_d;
  logic              err_q,     err_d;
  logic [CNT_W-1:0]  cnt_q,     cnt_d;
  logic [LINE_W-1:0] rd_block_q, rd_block_d;

  logic beat_is_last;

  // Only the error bit of the response matters; OKAY and EXOKAY are both fine.
  logic unused_rresp_lsb;
  assign unused_rresp_lsb = i_rresp[0];

  assign beat_is_last = (cnt_q == LAST_IDX);

  // Next-state and datapath logic for the whole refill transaction.
  always_comb begin
    state_d    = state_q;
    araddr_d   = araddr_q;
    arvalid_d  = arvalid_q;
    rready_d   = rready_q;
    r_last_d   = 1'b0;
    err_d      = err_q;
    cnt_d      = cnt_q;
    rd_block_d = rd_block_q;

    case (state_q)
      S_IDLE: begin
        if (i_start_read) begin
          araddr_d  = i_addr & LINE_MASK;
          err_d     = 1'b0;
          cnt_d     = '0;
          arvalid_d = 1'b1;
          state_d   = S_ADDR;
        end
      end

      S_ADDR: begin
        // arvalid stays up until the interconnect takes the address.
        if (i_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_DATA;
        end
      end

      S_DATA: begin
        if (i_rvalid) begin
          for (int k = 0; k < BLOCK_WORDS; k++) begin
            if (cnt_q == CNT_W'(k)) begin
              rd_block_d[k*DATA_W +: DATA_W] = i_rdata;
            end
          end
          if (i_rresp[1]) begin
            err_d = 1'b1;
          end
          // rlast must arrive exactly on the final beat; anything else is a
          // protocol error, but the line still completes.
          if (i_rlast != beat_is_last) begin
            err_d = 1'b1;
          end
          cnt_d = cnt_q + CNT_W'(1);
          if (beat_is_last || i_rlast) begin
            rready_d = 1'b0;
            r_last_d = 1'b1;
            state_d  = S_RESP;
          end
        end
      end

      S_RESP: begin
        // A request still held high must not start a second refill.
        state_d = i_start_read ? S_HOLD : S_IDLE;
      end

      S_HOLD: begin
        if (!i_start_read) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        arvalid_d = 1'b0;
        rready_d  = 1'b0;
        state_d   = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any burst in flight.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state_q    <= S_IDLE;
      araddr_q   <= '0;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
      r_last_q   <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
      rd_block_q <= '0;
    end else begin
      state_q    <= state_d;
      araddr_q   <= araddr_d;
      arvalid_q  <= arvalid_d;
      rready_q   <= rready_d;
      r_last_q   <= r_last_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
      rd_block_q <= rd_block_d;
    end
  end

  assign o_araddr   = araddr_q;
  assign o_arlen    = 8'(BLOCK_WORDS - 1);
  assign o_arvalid  = arvalid_q;
  assign o_rready   = rready_q;
  assign o_r_last   = r_last_q;
  assign o_err      = err_q;
  assign o_rd_block = rd_block_q;

endmodule

// File: tb/tb_cache_refill_engine.sv
// tb_cache_refill_engine: drives the refill engine with an AXI read slave
// behaviour (optional AR stall, random R gaps, injected errors) and compares the
// completion timing, error flag and assembled line against a line-level model.
module tb_cache_refill_engine;

  localparam int ADDR_W = 64;
  localparam int DATA_W = 32;
  localparam int BW     = 16;
  localparam int LINE_W = BW * DATA_W;

  logic              clk = 1'b0;
  logic              arst = 1'b1;
  logic              i_start_read = 1'b0;
  logic [ADDR_W-1:0] i_addr = '0;
  logic [LINE_W-1:0] o_rd_block;
  logic              o_r_last;
  logic              o_err;
  logic [ADDR_W-1:0] o_araddr;
  logic [7:0]        o_arlen;
  logic              o_arvalid;
  logic              i_arready = 1'b0;
  logic [DATA_W-1:0] i_rdata = '0;
  logic [1:0]        i_rresp = 2'b00;
  logic              i_rlast = 1'b0;
  logic              i_rvalid = 1'b0;
  logic              o_rready;

  // Free-running clock, posedges at 5, 15, 25, ...
  always #5 clk = ~clk;

  cache_refill_engine #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BLOCK_WORDS(BW)
  ) dut (
    .clk(clk), .arst(arst), .i_start_read(i_start_read), .i_addr(i_addr),
    .o_rd_block(o_rd_block), .o_r_last(o_r_last), .o_err(o_err),
    .o_araddr(o_araddr), .o_arlen(o_arlen), .o_arvalid(o_arvalid),
    .i_arready(i_arready), .i_rdata(i_rdata), .i_rresp(i_rresp),
    .i_rlast(i_rlast), .i_rvalid(i_rvalid), .o_rready(o_rready)
  );

  int checks = 0;
  int errors = 0;

  // Line-level reference: contents the cache line should hold right now.
  logic [DATA_W-1:0] ref_line [BW];

  // Observations gathered while a line is being fetched.
  int                obs_last_cycle;
  int                obs_pulses;
  int                obs_ar_bad;
  int                obs_second_ar;
  int                obs_rready_bad;
  int                obs_gaps;
  int                obs_beats;
  logic              obs_err;
  logic [LINE_W-1:0] obs_block;
  logic [ADDR_W-1:0] obs_araddr;

  function automatic logic [LINE_W-1:0] ref_packed();
    logic [LINE_W-1:0] v;
    for (int k = 0; k < BW; k++) v[k*DATA_W +: DATA_W] = ref_line[k];
    return v;
  endfunction

  function automatic int exp_last_cycle(input int ar_delay, input int gaps, input int last_beat);
    int nbeats;
    nbeats = (last_beat >= 0 && last_beat < BW - 1) ? last_beat + 1 : BW;
    return 2 + ar_delay + gaps + nbeats;
  endfunction

  // Drives one request through an AXI slave behaviour. Cycle 0 is the cycle in
  // which the engine first sees the request. last_beat < 0 means no rlast at all.
  task automatic run_line(input logic [ADDR_W-1:0] addr, input int ar_delay, input int gap_pct,
                          input int bad_beat, input int last_beat, input int hold_after,
                          input int drop_at, input bit seq_data);
    logic [ADDR_W-1:0] exp_addr;
    int cyc, beat, ar_seen;
    bit ar_done, ended, accepted, last_seen, got_ar;
    exp_addr = addr & ~64'h3f;
    obs_last_cycle = -1; obs_pulses = 0; obs_ar_bad = 0; obs_second_ar = 0;
    obs_rready_bad = 0; obs_gaps = 0; obs_beats = 0; obs_err = 1'b0;
    obs_block = '0; obs_araddr = '0;
    cyc = 0; beat = 0; ar_seen = 0;
    ar_done = 0; ended = 0; accepted = 0; last_seen = 0; got_ar = 0;
    @(posedge clk); #1;
    i_start_read = 1'b1; i_addr = addr; i_arready = 1'b0;
    i_rvalid = 1'b0; i_rlast = 1'b0; i_rresp = 2'b00;
    forever begin
      @(negedge clk);
      if (o_r_last) begin
        obs_pulses++;
        if (!last_seen) begin
          obs_last_cycle = cyc; obs_err = o_err; obs_block = o_rd_block;
        end
        last_seen = 1;
      end
      if (o_arvalid) begin
        if (!got_ar) begin obs_araddr = o_araddr; got_ar = 1; end
        if (o_araddr !== exp_addr) obs_ar_bad++;
        if (ar_done) obs_second_ar++;
      end
      if (o_rready && (!ar_done || ended)) obs_rready_bad++;
      accepted = 0;
      if (ar_done && !ended) begin
        if (i_rvalid && o_rready) begin
          ref_line[beat] = i_rdata;
          obs_beats++;
          accepted = 1;
          if (beat == BW - 1 || i_rlast) ended = 1;
          beat++;
        end else if (!i_rvalid) begin
          obs_gaps++;
        end
      end
      if (o_arvalid && i_arready) ar_done = 1;
      if (last_seen && cyc >= obs_last_cycle + hold_after + 3) break;
      if (cyc >= 300) break;
      @(posedge clk); #1;
      cyc++;
      i_start_read = !(drop_at >= 0 && cyc >= drop_at) &&
                     (!last_seen || (cyc - obs_last_cycle) <= hold_after);
      if (o_arvalid && !ar_done) begin
        i_arready = (ar_seen >= ar_delay);
        ar_seen++;
      end else begin
        i_arready = 1'b0;
      end
      if (accepted || ended) begin
        i_rvalid = 1'b0; i_rlast = 1'b0; i_rresp = 2'b00;
      end
      if (ar_done && !ended && !i_rvalid && (gap_pct == 0 || $urandom_range(99) >= gap_pct)) begin
        i_rvalid = 1'b1;
        i_rdata  = seq_data ? DATA_W'(beat) : DATA_W'($urandom);
        i_rresp  = (beat == bad_beat) ? 2'b10 : 2'b00;
        i_rlast  = (beat == last_beat);
      end
    end
    i_start_read = 1'b0; i_arready = 1'b0; i_rvalid = 1'b0; i_rlast = 1'b0; i_rresp = 2'b00;
  endtask

  // Asynchronous reset values, checked before any clock edge.
  task automatic test_reset();
    #2 arst = 1'b0;
    #1;
    for (int k = 0; k < BW; k++) ref_line[k] = '0;
    checks++;
    if ({o_arvalid, o_rready, o_r_last, o_err} !== 4'b0000) begin
      errors++; $display("[TB] FAIL reset_flags: got %b expected 0000", {o_arvalid, o_rready, o_r_last, o_err});
    end
    checks++;
    if (o_araddr !== '0) begin
      errors++; $display("[TB] FAIL reset_araddr: got %h expected 0", o_araddr);
    end
    checks++;
    if (o_rd_block !== '0) begin
      errors++; $display("[TB] FAIL reset_block: got %h expected 0", o_rd_block);
    end
    checks++;
    if (o_arlen !== 8'd15) begin
      errors++; $display("[TB] FAIL reset_arlen: got %0d expected 15", o_arlen);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) arst = 1'b1;
  endtask

  // Zero-wait memory, data = beat index, address inside a line.
  task automatic test_basic();
    logic [LINE_W-1:0] exp_blk;
    for (int k = 0; k < BW; k++) exp_blk[k*DATA_W +: DATA_W] = DATA_W'(k);
    run_line(64'h1234, 0, 0, -1, BW - 1, 0, -1, 1'b1);
    checks++;
    if (obs_araddr !== 64'h1200 || obs_ar_bad != 0) begin
      errors++; $display("[TB] FAIL basic_araddr: got %h (bad cycles %0d) expected 1200", obs_araddr, obs_ar_bad);
    end
    checks++;
    if (obs_last_cycle != 18) begin
      errors++; $display("[TB] FAIL basic_latency: got %0d expected 18", obs_last_cycle);
    end
    checks++;
    if (obs_pulses != 1) begin
      errors++; $display("[TB] FAIL basic_pulses: got %0d expected 1", obs_pulses);
    end
    checks++;
    if (obs_err !== 1'b0) begin
      errors++; $display("[TB] FAIL basic_err: got %b expected 0", obs_err);
    end
    checks++;
    if (obs_block !== exp_blk) begin
      errors++; $display("[TB] FAIL basic_block: got %h expected %h", obs_block, exp_blk);
    end
    checks++;
    if (obs_rready_bad != 0) begin
      errors++; $display("[TB] FAIL basic_rready: got %0d stray cycles expected 0", obs_rready_bad);
    end
  endtask

  // Address channel held off for five cycles.
  task automatic test_ar_backpressure();
    run_line({$urandom, $urandom}, 5, 0, -1, BW - 1, 0, -1, 1'b0);
    checks++;
    if (obs_ar_bad != 0) begin
      errors++; $display("[TB] FAIL ar_stable: got %0d unstable cycles expected 0", obs_ar_bad);
    end
    checks++;
    if (obs_last_cycle != 23) begin
      errors++; $display("[TB] FAIL ar_latency: got %0d expected 23", obs_last_cycle);
    end
    checks++;
    if (obs_block !== ref_packed()) begin
      errors++; $display("[TB] FAIL ar_block: got %h expected %h", obs_block, ref_packed());
    end
  endtask

  // Roughly half the data cycles carry no beat.
  task automatic test_random_gaps();
    for (int n = 0; n < 3; n++) begin
      run_line({$urandom, $urandom}, int'($urandom_range(2)), 50, -1, BW - 1, 0, -1, 1'b0);
      checks++;
      if (obs_last_cycle != exp_last_cycle(obs_ar_bad == 0 ? obs_last_cycle - 2 - obs_gaps - BW : 0, obs_gaps, BW - 1)
          || obs_last_cycle < 2 + obs_gaps + BW || obs_last_cycle > 4 + obs_gaps + BW) begin
        errors++; $display("[TB] FAIL gaps_latency: got %0d with %0d gaps", obs_last_cycle, obs_gaps);
      end
      checks++;
      if (obs_block !== ref_packed()) begin
        errors++; $display("[TB] FAIL gaps_block: got %h expected %h", obs_block, ref_packed());
      end
      checks++;
      if (obs_rready_bad != 0 || obs_err !== 1'b0) begin
        errors++; $display("[TB] FAIL gaps_rready_err: got %0d stray / err %b expected 0 / 0", obs_rready_bad, obs_err);
      end
    end
  endtask

  // SLVERR in mid-burst: full line, error flagged and held afterwards.
  task automatic test_slverr();
    run_line({$urandom, $urandom}, 0, 0, 7, BW - 1, 0, -1, 1'b0);
    checks++;
    if (obs_last_cycle != exp_last_cycle(0, 0, BW - 1) || obs_err !== 1'b1) begin
      errors++; $display("[TB] FAIL slverr_done: got cycle %0d err %b expected 18 1", obs_last_cycle, obs_err);
    end
    checks++;
    if (obs_block !== ref_packed()) begin
      errors++; $display("[TB] FAIL slverr_block: got %h expected %h", obs_block, ref_packed());
    end
    checks++;
    if (o_err !== 1'b1 || o_rd_block !== ref_packed()) begin
      errors++; $display("[TB] FAIL slverr_hold: got err %b expected 1 with line held", o_err);
    end
  endtask

  // rlast on beat 9: early completion, tail words keep the previous line.
  task automatic test_early_last();
    run_line({$urandom, $urandom}, 0, 0, -1, 9, 0, -1, 1'b0);
    checks++;
    if (obs_last_cycle != 12 || obs_beats != 10) begin
      errors++; $display("[TB] FAIL early_done: got cycle %0d beats %0d expected 12 10", obs_last_cycle, obs_beats);
    end
    checks++;
    if (obs_err !== 1'b1) begin
      errors++; $display("[TB] FAIL early_err: got %b expected 1", obs_err);
    end
    checks++;
    if (obs_block !== ref_packed()) begin
      errors++; $display("[TB] FAIL early_block: got %h expected %h", obs_block, ref_packed());
    end
  endtask

  // No rlast on the final beat: completes anyway with an error.
  task automatic test_missing_last();
    run_line({$urandom, $urandom}, 0, 0, -1, -1, 0, -1, 1'b0);
    checks++;
    if (obs_last_cycle != 18 || obs_err !== 1'b1) begin
      errors++; $display("[TB] FAIL missing_done: got cycle %0d err %b expected 18 1", obs_last_cycle, obs_err);
    end
    checks++;
    if (obs_block !== ref_packed()) begin
      errors++; $display("[TB] FAIL missing_block: got %h expected %h", obs_block, ref_packed());
    end
  endtask

  // Request held after completion, and request dropped mid-burst.
  task automatic test_request_lifetime();
    run_line({$urandom, $urandom}, 0, 0, -1, BW - 1, 4, -1, 1'b0);
    checks++;
    if (obs_second_ar != 0 || obs_pulses != 1) begin
      errors++; $display("[TB] FAIL hold_retrigger: got %0d extra AR cycles %0d pulses expected 0 1", obs_second_ar, obs_pulses);
    end
    run_line({$urandom, $urandom}, 0, 0, -1, BW - 1, 0, 5, 1'b0);
    checks++;
    if (obs_last_cycle != 18 || obs_pulses != 1) begin
      errors++; $display("[TB] FAIL drop_complete: got cycle %0d pulses %0d expected 18 1", obs_last_cycle, obs_pulses);
    end
    checks++;
    if (obs_block !== ref_packed()) begin
      errors++; $display("[TB] FAIL drop_block: got %h expected %h", obs_block, ref_packed());
    end
  endtask

  // Reset asserted in the middle of a burst, then a normal refill.
  task automatic test_reset_mid_burst();
    @(posedge clk); #1;
    i_start_read = 1'b1; i_addr = {$urandom, $urandom};
    i_arready = 1'b1; i_rvalid = 1'b1; i_rdata = DATA_W'($urandom);
    i_rlast = 1'b0; i_rresp = 2'b00;
    repeat (6) @(posedge clk);
    #2 arst = 1'b0;
    #1;
    for (int k = 0; k < BW; k++) ref_line[k] = '0;
    checks++;
    if ({o_arvalid, o_rready, o_r_last, o_err} !== 4'b0000 || o_araddr !== '0) begin
      errors++; $display("[TB] FAIL midreset_ctrl: got flags %b addr %h expected 0000 0",
                         {o_arvalid, o_rready, o_r_last, o_err}, o_araddr);
    end
    checks++;
    if (o_rd_block !== '0) begin
      errors++; $display("[TB] FAIL midreset_block: got %h expected 0", o_rd_block);
    end
    i_start_read = 1'b0; i_arready = 1'b0; i_rvalid = 1'b0;
    @(negedge clk) arst = 1'b1;
    run_line({$urandom, $urandom}, 0, 0, -1, BW - 1, 0, -1, 1'b0);
    checks++;
    if (obs_last_cycle != 18 || obs_err !== 1'b0 || obs_pulses != 1) begin
      errors++; $display("[TB] FAIL midreset_next: got cycle %0d err %b pulses %0d expected 18 0 1",
                         obs_last_cycle, obs_err, obs_pulses);
    end
    checks++;
    if (obs_block !== ref_packed()) begin
      errors++; $display("[TB] FAIL midreset_next_block: got %h expected %h", obs_block, ref_packed());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ar_backpressure();
    test_random_gaps();
    test_slverr();
    test_early_last();
    test_missing_last();
    test_request_lifetime();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
